// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the mem-stage interface.
// Serialises one read or write at a time and answers after a fixed latency.
module dmem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mis_q, mis_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     ram_q [0:(1<<AW)-1];

  logic            enter_resp_s;
  logic            acc_we_s;
  logic [AW-1:0]   acc_idx_s;
  logic [31:0]     acc_wdata_s;
  logic            acc_mis_s;
  logic            ram_we_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^req_addr[31:AW+2];

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

  // With a one-cycle latency the access happens on the accepting edge, so the
  // live request is used instead of the (not yet captured) copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we_s    = req_we;
      acc_idx_s   = req_addr[AW+1:2];
      acc_wdata_s = req_wdata;
      acc_mis_s   = (req_addr[1:0] != 2'b00);
    end else begin
      acc_we_s    = we_q;
      acc_idx_s   = idx_q;
      acc_wdata_s = wdata_q;
      acc_mis_s   = mis_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mis_d        = mis_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rdata_d      = rdata_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          mis_d   = (req_addr[1:0] != 2'b00);
          if (LATENCY == 1) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end
    endcase
    if (enter_resp_s) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_mis_s;
      if (!acc_mis_s && !acc_we_s) begin
        rdata_d = ram_q[acc_idx_s];
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      enter_resp_s = 1'b0;
    end
  end

  // Gating with rst keeps a write that races reset from committing.
  assign ram_we_s = enter_resp_s && acc_we_s && !acc_mis_s && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      mis_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mis_q        <= mis_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[acc_idx_s] <= acc_wdata_s;
    end
  end

endmodule
